// File: rtl/ulx3s_reset_pkg.sv
// Shared types and parameter defaults for the ULX3S reset sequencer.
package ulx3s_reset_pkg;

    // Sequencer phases: hold everything, wait for lock to settle,
    // release video, then release the rest of the system.
    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_STABLE = 2'd1,
        ST_VIDEO  = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

    localparam int unsigned LOCK_STABLE_CYCLES_DEFAULT  = 65536;
    localparam int unsigned STAGGER_CYCLES_DEFAULT      = 16;
    localparam int unsigned BTN_DEBOUNCE_CYCLES_DEFAULT = 1024;

endpackage : ulx3s_reset_pkg

// File: rtl/ulx3s_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module ulx3s_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : ulx3s_sync2

// File: rtl/ulx3s_reset_sequencer.sv
// Power-up / lock-loss / button reset sequencer for the ULX3S board.
// Holds video and system resets until the PLL lock has been stable for a
// while, then releases video first and the system a little later.
module ulx3s_reset_sequencer
    import ulx3s_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEFAULT,
    parameter int unsigned STAGGER_CYCLES      = STAGGER_CYCLES_DEFAULT,
    parameter int unsigned BTN_DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       btn_reset,
    output logic       video_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_lost_count
);

    localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int unsigned GW = $clog2(STAGGER_CYCLES) + 1;
    localparam int unsigned BW = $clog2(BTN_DEBOUNCE_CYCLES) + 1;

    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] STAG_LAST = GW'(STAGGER_CYCLES - 1);
    localparam logic [BW-1:0] BTN_LAST  = BW'(BTN_DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BTN_TOP   = BW'(BTN_DEBOUNCE_CYCLES);

    logic lock_s;
    logic btn_s;

    seq_state_t    state, state_nx;
    logic [SW-1:0] stab_cnt, stab_cnt_nx;
    logic [GW-1:0] stag_cnt, stag_cnt_nx;
    logic [BW-1:0] btn_cnt, btn_cnt_nx;
    logic [7:0]    lost_nx;
    logic          video_reset_nx;
    logic          sys_reset_nx;
    logic          ready_nx;

    logic btn_fire;
    logic btn_busy;
    logic btn_hold;
    logic lock_loss;

    ulx3s_sync2 u_sync_lock (
        .clk   (clk50),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    ulx3s_sync2 u_sync_btn (
        .clk   (clk50),
        .rst_n (rst_n),
        .d     (btn_reset),
        .q     (btn_s)
    );

    // Button request decode: fire once when the debounce count is reached,
    // then keep holding until the synced button goes low again. The debounce
    // counter parks at its top value so a long press never re-fires.
    always_comb begin
        btn_fire  = btn_s && (btn_cnt == BTN_LAST);
        btn_busy  = btn_s && (btn_cnt == BTN_TOP);
        btn_hold  = btn_fire || btn_busy;
        lock_loss = (state != ST_HOLD) && !lock_s;

        btn_cnt_nx = btn_cnt;
        if (!btn_s) begin
            btn_cnt_nx = '0;
        end else if (btn_cnt != BTN_TOP) begin
            btn_cnt_nx = btn_cnt + BW'(1);
        end
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_nx       = state;
        stab_cnt_nx    = '0;
        stag_cnt_nx    = '0;
        lost_nx        = lock_lost_count;
        video_reset_nx = 1'b1;
        sys_reset_nx   = 1'b1;
        ready_nx       = 1'b0;

        if (lock_loss && (lock_lost_count != 8'hFF)) begin
            lost_nx = lock_lost_count + 8'd1;
        end

        if (btn_hold) begin
            state_nx = ST_HOLD;
        end else begin
            unique case (state)
                ST_HOLD: begin
                    if (lock_s) state_nx = ST_STABLE;
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nx = ST_HOLD;
                    end else if (stab_cnt == STAB_LAST) begin
                        state_nx = ST_VIDEO;
                    end else begin
                        stab_cnt_nx = stab_cnt + SW'(1);
                    end
                end
                ST_VIDEO: begin
                    if (!lock_s) begin
                        state_nx = ST_HOLD;
                    end else if (stag_cnt == STAG_LAST) begin
                        state_nx = ST_RUN;
                    end else begin
                        stag_cnt_nx = stag_cnt + GW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) state_nx = ST_HOLD;
                end
                default: state_nx = ST_HOLD;
            endcase
        end

        // Outputs are registered from the next state so they change on the
        // first cycle spent in the new state.
        unique case (state_nx)
            ST_VIDEO: begin
                video_reset_nx = 1'b0;
            end
            ST_RUN: begin
                video_reset_nx = 1'b0;
                sys_reset_nx   = 1'b0;
                ready_nx       = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and outputs; resets assert immediately on rst_n.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_HOLD;
            stab_cnt        <= '0;
            stag_cnt        <= '0;
            btn_cnt         <= '0;
            lock_lost_count <= '0;
            video_reset     <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
        end else begin
            state           <= state_nx;
            stab_cnt        <= stab_cnt_nx;
            stag_cnt        <= stag_cnt_nx;
            btn_cnt         <= btn_cnt_nx;
            lock_lost_count <= lost_nx;
            video_reset     <= video_reset_nx;
            sys_reset       <= sys_reset_nx;
            ready           <= ready_nx;
        end
    end

endmodule : ulx3s_reset_sequencer

// File: tb/tb_ulx3s_reset_sequencer.sv
// Self-checking bench for ulx3s_reset_sequencer with small parameters.
module tb_ulx3s_reset_sequencer;

    localparam int LOCK = 8;
    localparam int STAG = 4;
    localparam int BTN  = 4;

    logic       clk50;
    logic       rst_n;
    logic       pll_locked;
    logic       btn_reset;
    logic       video_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] lock_lost_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one elapsed-time value for the whole release sequence.
    // t_seq = -1 while held; otherwise cycles since lock was first seen stable.
    bit m_l1, m_l2, m_b1, m_b2;
    int t_seq;
    int btn_len;
    int m_cnt;

    ulx3s_reset_sequencer #(
        .LOCK_STABLE_CYCLES  (LOCK),
        .STAGGER_CYCLES      (STAG),
        .BTN_DEBOUNCE_CYCLES (BTN)
    ) dut (
        .clk50           (clk50),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .btn_reset       (btn_reset),
        .video_reset     (video_reset),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .lock_lost_count (lock_lost_count)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0;
        t_seq = -1; btn_len = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit lk, bt, active;
        lk = m_l2;
        bt = m_b2;
        active = bt && (btn_len >= BTN - 1);
        btn_len = bt ? btn_len + 1 : 0;
        if (t_seq >= 0 && !lk && m_cnt < 255) m_cnt++;
        if (active || !lk) t_seq = -1;
        else if (t_seq < LOCK + STAG) t_seq++;
        m_l2 = m_l1; m_l1 = pll_locked;
        m_b2 = m_b1; m_b1 = btn_reset;
    endtask

    // One clock: advance model at the edge, compare all outputs just after.
    task automatic tick();
        logic exp_vr, exp_sr;
        @(posedge clk50);
        model_step();
        #1;
        exp_vr = (t_seq < LOCK);
        exp_sr = (t_seq < LOCK + STAG);
        chk("outs", {21'd0, video_reset, sys_reset, ready, lock_lost_count},
                    {21'd0, exp_vr, exp_sr, ~exp_sr, m_cnt[7:0]});
    endtask

    // Assert rst_n between edges and confirm the outputs react without a clock.
    task automatic apply_reset();
        @(negedge clk50);
        #3 rst_n = 1'b0;
        pll_locked = 1'b0;
        btn_reset  = 1'b0;
        #1;
        chk("async_rst", {28'd0, video_reset, sys_reset, ready, 1'b0}, 32'hC);
        chk("async_cnt", {24'd0, lock_lost_count}, 32'd0);
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic measure_release(output int vf, output int sf);
        vf = -1; sf = -1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (vf < 0 && !video_reset) vf = c;
            if (sf < 0 && !sys_reset) sf = c;
        end
    endtask

    initial begin
        int vf, sf, falls;
        int lk_left, bt_left;
        logic prev_rdy;

        rst_n = 1'b0;
        pll_locked = 1'b0;
        btn_reset = 1'b0;
        model_reset();
        #35;
        chk("por_outs", {28'd0, video_reset, sys_reset, ready, 1'b0}, 32'hC);

        // Power-up release timing.
        apply_reset();
        pll_locked = 1'b1;
        measure_release(vf, sf);
        chk("vid_fall", vf, 11);
        chk("sys_fall", sf, 15);
        chk("ready_run", {31'd0, ready}, 32'd1);

        // Lock dropout during STABLE restarts the count.
        apply_reset();
        pll_locked = 1'b1;
        for (int i = 0; i < 20 && t_seq != 5; i++) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        measure_release(vf, sf);
        chk("relock_vid_fall", vf, 11);
        chk("relock_cnt", {24'd0, lock_lost_count}, 32'd1);

        // Repeated lock loss in RUN saturates the counter.
        apply_reset();
        pll_locked = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wait_ready(40);
            pll_locked = 1'b0;
            tick();
            tick();
            chk("loss_pre", {31'd0, video_reset}, 32'd0);
            tick();
            chk("loss_3cyc", {30'd0, video_reset, sys_reset}, 32'd3);
            pll_locked = 1'b1;
        end
        wait_ready(40);
        chk("sat_255", {24'd0, lock_lost_count}, 32'd255);

        // Button: short bounces ignored, one long press forces one HOLD.
        apply_reset();
        pll_locked = 1'b1;
        wait_ready(40);
        for (int i = 0; i < 5; i++) begin
            btn_reset = 1'b1;
            repeat (3) tick();
            btn_reset = 1'b0;
            repeat (3) tick();
        end
        chk("bounce_ready", {31'd0, ready}, 32'd1);
        btn_reset = 1'b1;
        falls = 0;
        prev_rdy = ready;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (prev_rdy && !ready) falls++;
            prev_rdy = ready;
        end
        btn_reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (prev_rdy && !ready) falls++;
            prev_rdy = ready;
        end
        chk("btn_falls", falls, 1);
        chk("btn_cnt_same", {24'd0, lock_lost_count}, 32'd0);
        wait_ready(40);
        chk("btn_restart", {31'd0, ready}, 32'd1);

        // Lock loss and button request land on the same edge.
        btn_reset = 1'b1;
        repeat (3) tick();
        pll_locked = 1'b0;
        repeat (4) tick();
        btn_reset = 1'b0;
        pll_locked = 1'b1;
        wait_ready(40);
        chk("combo_cnt", {24'd0, lock_lost_count}, 32'd1);

        // Async reset while running clears everything (checked inside).
        apply_reset();

        // Randomized lock and button activity.
        pll_locked = 1'b1;
        lk_left = 0;
        bt_left = 20;
        for (int i = 0; i < 4000; i++) begin
            if (lk_left == 0) begin
                pll_locked = ~pll_locked;
                lk_left = pll_locked ? $urandom_range(5, 40) : $urandom_range(1, 5);
            end
            if (bt_left == 0) begin
                btn_reset = ~btn_reset;
                bt_left = btn_reset ? $urandom_range(1, 8) : $urandom_range(10, 60);
            end
            lk_left--;
            bt_left--;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ulx3s_reset_sequencer

// File: doc/ulx3s_reset_sequencer.md
ULX3S_RESET_SEQUENCER -- requirements
Module: ulx3s_reset_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 65536: cycles synced lock must stay high before any reset release (~1.3 ms at 50 MHz).
REQ-002 Parameter STAGGER_CYCLES, default 16: cycles between video reset release and system reset release.
REQ-003 Parameter BTN_DEBOUNCE_CYCLES, default 1024: cycles synced button must stay high to count as a reset request.
REQ-004 clk50  in  1  single clock, 50 MHz CLKOP of the board PLL; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pll_locked  in  1  PLL LOCK, asynchronous to clk50.
REQ-007 btn_reset  in  1  user reset button, active-high, asynchronous, bouncy.
REQ-008 video_reset  out  1  active-high reset for the video-side logic, asserted asynchronously, deasserted synchronously.
REQ-009 sys_reset  out  1  active-high reset for CPU/GPU logic, same timing rules.
REQ-010 ready  out  1  high only in RUN.
REQ-011 lock_lost_count  out  8  saturating count of lock-loss events.

Function
REQ-012 pll_locked and btn_reset SHALL each pass a 2-flop synchronizer; "lock_s"/"btn_s" denote the synchronizer outputs.
REQ-013 FSM states: HOLD, STABLE, VIDEO, RUN; all outputs registered.
REQ-014 HOLD: video_reset=1, sys_reset=1, ready=0; lock_s=1 -> STABLE with the stable counter cleared.
REQ-015 STABLE: counter increments each cycle while lock_s=1; at count LOCK_STABLE_CYCLES-1 -> VIDEO.
REQ-016 VIDEO: video_reset=0, sys_reset=1; stagger counter runs; after STAGGER_CYCLES cycles in VIDEO -> RUN.
REQ-017 RUN: video_reset=0, sys_reset=0, ready=1.
REQ-018 Output timing: video_reset falls on the first cycle in VIDEO; sys_reset and ready change on the first cycle in RUN.
REQ-019 lock_s=0 in STABLE, VIDEO or RUN -> HOLD next cycle, both resets reasserted, both counters cleared.
REQ-020 lock_lost_count increments by 1 on each such transition and saturates at 255 with no wrap.
REQ-021 Debounce counter: counts while btn_s=1 and clears whenever btn_s=0.
REQ-022 Reaching BTN_DEBOUNCE_CYCLES SHALL force HOLD from any state and generate exactly one request per press; re-arm only after btn_s=0.
REQ-023 Button request without lock loss SHALL NOT increment lock_lost_count.
REQ-024 Lock loss and button request in the same cycle -> HOLD; count incremented exactly once.
REQ-025 HOLD SHALL remain while the button request is active (btn_s still 1 after firing); STABLE is entered only after btn_s=0 and lock_s=1.
REQ-026 Counter widths: $clog2 of the respective parameter plus 1; no overflow for any legal parameter value >= 1.

Reset
REQ-027 rst_n=0 SHALL immediately set video_reset=1 and sys_reset=1, asynchronously, without a clock edge.
REQ-028 Reset values: state=HOLD, ready=0, lock_lost_count=0, all counters 0, synchronizer flops 0.
REQ-029 rst_n deassertion mid-sequence SHALL restart from HOLD; release of rst_n is treated as synchronous to clk50 by the board-level reset source.

Structure
REQ-030 Shared package ulx3s_reset_pkg: state enumeration type and the three parameter default constants.
REQ-031 One sub-module, ulx3s_sync2 (2-flop synchronizer, async active-low reset to 0), instantiated twice.

Verification (LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4, BTN_DEBOUNCE_CYCLES=4)
REQ-032 Release rst_n, raise pll_locked at cycle 0 -> video_reset falls at cycle 11 (2 sync + 1 HOLD + 8 STABLE), sys_reset and ready change at cycle 15.
REQ-033 pll_locked drops for 3 cycles during STABLE at count 5 -> HOLD, counter restarts from 0; lock_lost_count=1; release occurs 8 stable cycles after relock.
REQ-034 Lock loss in RUN, repeated 300 times -> resets reassert 3 cycles after each drop; lock_lost_count saturates at 255.
REQ-035 btn_reset bounce of 3-cycle high pulses -> no effect; 6-cycle press in RUN -> HOLD once, lock_lost_count unchanged, sequence restarts after release.
REQ-036 Assert rst_n=0 mid-cycle during RUN -> video_reset=sys_reset=1 before the next clk50 edge, all state cleared; same-cycle lock loss + button -> count +1 exactly.
